delay_mem_arbiter: RTL and testbench
====================================

DELAY_MEM_ARBITER -- requirements
Module: delay_mem_arbiter

Interface
REQ-001 SHALL have parameter N_CLIENTS, default 4: number of delay-line engines sharing one SRAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: sample width.
REQ-003 SHALL have parameter MEM_SIZE, default 8192: SRAM depth in words; AW = clog2(MEM_SIZE).
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 cl_wr_req  in  N_CLIENTS  per-client write request, level, held until its ack.
REQ-007 cl_wr_addr  in  N_CLIENTS*AW  per-client write address; client i in bits [i*AW +: AW].
REQ-008 cl_wr_data  in  N_CLIENTS*DATA_WIDTH  per-client write data, same packing.
REQ-009 cl_wr_ack  out  N_CLIENTS  one-cycle write-done pulse per client.
REQ-010 cl_rd_req  in  N_CLIENTS  per-client read request, level, held until its valid.
REQ-011 cl_rd_addr  in  N_CLIENTS*AW  per-client read address.
REQ-012 cl_rd_data  out  DATA_WIDTH  shared read-data bus, meaningful only with a cl_rd_valid bit.
REQ-013 cl_rd_valid  out  N_CLIENTS  one-cycle read-done pulse per client.
REQ-014 sram_addr  out  AW; sram_we  out  1; sram_wdata  out  DATA_WIDTH; sram_en  out  1: single-port SRAM command, all registered.
REQ-015 sram_rdata  in  DATA_WIDTH: SRAM read data, valid the cycle after an sram_en=1, sram_we=0 command.
REQ-016 addr_err  out  1: one-cycle pulse on an out-of-range access.

Function
REQ-017 States SHALL be IDLE, CMD, RD_WAIT, RD_CAP.
REQ-018 IDLE, request arbitration:
- a client is pending if its wr_req or rd_req is high;
- winner is the first pending client at or after rr_ptr, in increasing index with wrap;
- winner latched, next state CMD.
REQ-019 Op select: if the winner has both wr_req and rd_req high, write is served first. The read is served at the client's next grant.
REQ-020 Write in CMD: sram_en=1, sram_we=1, addr/wdata from winner, cl_wr_ack[winner]=1 the same cycle, next IDLE.
- Write latency: request sampled in cycle T, ack in T+1.
REQ-021 Read sequence:
- CMD drives sram_en=1, sram_we=0, addr from winner, then RD_WAIT.
- RD_WAIT captures sram_rdata into cl_rd_data, then RD_CAP.
- RD_CAP pulses cl_rd_valid[winner]=1, then IDLE.
- Read latency: request sampled T, valid in T+3.
REQ-022 rr_ptr SHALL update to winner+1 (mod N_CLIENTS) on each grant, including when winner is N_CLIENTS-1, where it wraps to 0.
REQ-023 No request SHALL be re-granted before its ack/valid pulse has been seen; IDLE re-samples only the cycle after the pulse.
REQ-024 cl_rd_data SHALL hold its last value until the next capture.
REQ-025 sram_en, sram_we SHALL be 0 in every state except CMD.
REQ-026 Address out of range (addr >= MEM_SIZE, possible only when MEM_SIZE is not a power of 2): checked in IDLE on the winner's selected operation.
- No SRAM command issued (sram_en stays 0).
- addr_err pulses in CMD.
- Write: ack pulses in CMD.
- Read: cl_rd_data=0 and valid in CMD.
- Next state IDLE; the client never hangs.
REQ-027 Requests deasserted before grant SHALL be ignored; requests withdrawn after grant SHALL still complete.
REQ-028 Fairness: any continuously pending client SHALL be granted within N_CLIENTS grants.

Reset
REQ-029 On reset, regardless of state, the following SHALL be 0: state=IDLE, rr_ptr=0, cl_wr_ack, cl_rd_valid, cl_rd_data, sram_en, sram_we, sram_addr, sram_wdata, addr_err.
REQ-030 Reset mid-read SHALL abort without emitting cl_rd_valid. Reset mid-write SHALL suppress the ack if asserted in the CMD cycle.

Verification
REQ-031 Single write: client 2 writes addr 0x0010, data 0x1234 at T.
- Expect in T+1: sram_we=1, sram_addr=0x0010, cl_wr_ack=4'b0100.
- Then a client 2 read of 0x0010 returns 0x1234 with cl_rd_valid=4'b0100 three cycles after its request.
REQ-032 All four clients hold wr_req from reset release; expect acks in order 0,1,2,3,0 at 2-cycle spacing.
REQ-033 Client 1 asserts wr_req and rd_req together; expect the write acked first, then clients 0/2/3 served before client 1's read when they are pending.
REQ-034 Client 3 wins with rr_ptr=3; expect rr_ptr wraps to 0 and client 0 is granted next.
REQ-035 With MEM_SIZE=6000, client 0 reads addr 6000; expect addr_err=1, sram_en=0, cl_rd_valid=4'b0001, cl_rd_data=0.
REQ-036 Reset asserted in RD_WAIT; expect no cl_rd_valid, all outputs 0, and the next grant to client 0 if pending.

Source files
------------

// File: rtl/delay_mem_arbiter.sv
// delay_mem_arbiter
//   Shares one single-port SRAM between N_CLIENTS delay-line engines.
//   Requests are arbitrated round-robin. A client's write is served before
//   its read when both are raised together; the read waits for that
//   client's next grant. Every SRAM command and client response is
//   registered.
//
//   Write: request sampled in IDLE (cycle T), SRAM write and ack in T+1.
//   Read : request sampled in IDLE (cycle T), SRAM read in T+1, data
//          captured at the end of T+2, valid pulse in T+3.
//   An out-of-range address issues no SRAM command. The request completes
//   in the command cycle with addr_err, and a read returns zero data.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   cl_wr_req/addr/data/ack     per-client write channel (packed per client)
//   cl_rd_req/addr/valid        per-client read channel (packed per client)
//   cl_rd_data                  shared read data, qualified by cl_rd_valid
//   sram_en/we/addr/wdata       registered SRAM command
//   sram_rdata                  SRAM read data, valid the cycle after a read
//   addr_err                    one-cycle pulse on an out-of-range access
module delay_mem_arbiter #(
  parameter int N_CLIENTS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_SIZE   = 8192,
  localparam int AW = $clog2(MEM_SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CLIENTS-1:0]         cl_wr_req,
  input  logic [N_CLIENTS*AW-1:0]      cl_wr_addr,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0] cl_wr_data,
  output logic [N_CLIENTS-1:0]         cl_wr_ack,
  input  logic [N_CLIENTS-1:0]         cl_rd_req,
  input  logic [N_CLIENTS*AW-1:0]      cl_rd_addr,
  output logic [DATA_WIDTH-1:0]        cl_rd_data,
  output logic [N_CLIENTS-1:0]         cl_rd_valid,
  output logic [AW-1:0]                sram_addr,
  output logic                         sram_we,
  output logic [DATA_WIDTH-1:0]        sram_wdata,
  output logic                         sram_en,
  input  logic [DATA_WIDTH-1:0]        sram_rdata,
  output logic                         addr_err
);

  localparam int PW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam logic [AW:0]   MEM_LIMIT   = (AW+1)'(MEM_SIZE);
  localparam logic [PW-1:0] LAST_CLIENT = PW'(N_CLIENTS - 1);

  typedef enum logic [1:0] {IDLE, CMD, RD_WAIT, RD_CAP} state_t;

  state_t state, state_next;

  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         winner;
  logic                  op_is_wr;
  logic                  op_err;

  logic                  found;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         next_ptr;
  logic                  sel_wr;
  logic [AW-1:0]         sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  out_of_range;
  logic [N_CLIENTS-1:0]  pending;

  function automatic logic [N_CLIENTS-1:0] onehot(input logic [PW-1:0] idx);
    logic [N_CLIENTS-1:0] v;
    v = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (PW'(i) == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign pending = cl_wr_req | cl_rd_req;

  // Round-robin search: first pending client at or after rr_ptr, with wrap.
  always_comb begin
    int idx;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_CLIENTS) idx = idx - N_CLIENTS;
      if (!found && pending[PW'(idx)]) begin
        found   = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  // Winner's operation: write takes priority over a simultaneous read.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (PW'(i) == win_idx) begin
        sel_wr    = cl_wr_req[i];
        sel_addr  = cl_wr_req[i] ? cl_wr_addr[i*AW +: AW] : cl_rd_addr[i*AW +: AW];
        sel_wdata = cl_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Only reachable when MEM_SIZE is not a power of two.
  assign out_of_range = ({1'b0, sel_addr} >= MEM_LIMIT);
  assign next_ptr     = (win_idx == LAST_CLIENT) ? '0 : win_idx + PW'(1);

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = found ? CMD : IDLE;
      CMD:     state_next = (op_is_wr || op_err) ? IDLE : RD_WAIT;
      RD_WAIT: state_next = RD_CAP;
      RD_CAP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Grant bookkeeping, registered SRAM command and client responses.
  // All command/response outputs are pulses, cleared by default each cycle
  // and raised only on the transition into the cycle that shows them.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      winner      <= '0;
      op_is_wr    <= 1'b0;
      op_err      <= 1'b0;
      sram_en     <= 1'b0;
      sram_we     <= 1'b0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      cl_wr_ack   <= '0;
      cl_rd_valid <= '0;
      cl_rd_data  <= '0;
      addr_err    <= 1'b0;
    end else begin
      sram_en     <= 1'b0;
      sram_we     <= 1'b0;
      cl_wr_ack   <= '0;
      cl_rd_valid <= '0;
      addr_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            winner   <= win_idx;
            op_is_wr <= sel_wr;
            op_err   <= out_of_range;
            rr_ptr   <= next_ptr;
            addr_err <= out_of_range;
            if (!out_of_range) begin
              sram_en   <= 1'b1;
              sram_we   <= sel_wr;
              sram_addr <= sel_addr;
              if (sel_wr) sram_wdata <= sel_wdata;
            end
            if (sel_wr) begin
              cl_wr_ack <= onehot(win_idx);
            end else if (out_of_range) begin
              cl_rd_valid <= onehot(win_idx);
              cl_rd_data  <= '0;
            end
          end
        end
        RD_WAIT: begin
          cl_rd_data  <= sram_rdata;
          cl_rd_valid <= onehot(winner);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_mem_arbiter.sv
// Self-checking bench for delay_mem_arbiter: a table of single transactions,
// then hand-written multi-client sequences, all checked through a response
// scoreboard. A second instance with MEM_SIZE=6000 covers address errors.
module tb_delay_mem_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    wr_req, rd_req, wr_ack, rd_valid;
  logic [N*AW-1:0] wr_addr, rd_addr;
  logic [N*DW-1:0] wr_data;
  logic [DW-1:0]   rd_data, sram_wdata, sram_rdata;
  logic [AW-1:0]   sram_addr;
  logic            sram_we, sram_en, addr_err;

  logic [N-1:0]    wr_req2, rd_req2, wr_ack2, rd_valid2;
  logic [N*AW-1:0] wr_addr2, rd_addr2;
  logic [N*DW-1:0] wr_data2;
  logic [DW-1:0]   rd_data2, sram_wdata2, sram_rdata2;
  logic [AW-1:0]   sram_addr2;
  logic            sram_we2, sram_en2, addr_err2;

  delay_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cl_wr_req(wr_req), .cl_wr_addr(wr_addr), .cl_wr_data(wr_data), .cl_wr_ack(wr_ack),
    .cl_rd_req(rd_req), .cl_rd_addr(rd_addr), .cl_rd_data(rd_data), .cl_rd_valid(rd_valid),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata), .sram_en(sram_en),
    .sram_rdata(sram_rdata), .addr_err(addr_err)
  );

  delay_mem_arbiter #(.N_CLIENTS(4), .DATA_WIDTH(16), .MEM_SIZE(6000)) dut2 (
    .clk(clk), .reset(reset),
    .cl_wr_req(wr_req2), .cl_wr_addr(wr_addr2), .cl_wr_data(wr_data2), .cl_wr_ack(wr_ack2),
    .cl_rd_req(rd_req2), .cl_rd_addr(rd_addr2), .cl_rd_data(rd_data2), .cl_rd_valid(rd_valid2),
    .sram_addr(sram_addr2), .sram_we(sram_we2), .sram_wdata(sram_wdata2), .sram_en(sram_en2),
    .sram_rdata(sram_rdata2), .addr_err(addr_err2)
  );

  // SRAM model for the main instance.
  logic [DW-1:0] mem [0:8191];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  // Pattern ROM for the 6000-word instance.
  always @(posedge clk) begin
    if (sram_en2 && !sram_we2) sram_rdata2 <= {3'b000, sram_addr2} ^ 16'h5A5A;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no end of test, required $finish");
    $fatal(1);
  end

  typedef struct {
    bit            is_wr;
    int            client;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    int            client;
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  exp_t sb[$];
  int   resp_log[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   resp_cnt = 0;
  int   last_resp_cyc = 0;
  int   cmd_cyc = -1;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_we;
  logic [N-1:0]  keep_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // One clock: observe outputs at the falling edge, score responses, then
  // drop the requests that were answered, just after the next rising edge.
  task automatic step();
    logic [N-1:0] a, v;
    exp_t e;
    int who;
    @(negedge clk);
    a = wr_ack;
    v = rd_valid;
    if (sram_en === 1'b1) begin
      cmd_cyc = cyc; cmd_addr = sram_addr; cmd_we = sram_we; cmd_wdata = sram_wdata;
    end
    if ((a | v) != '0) begin
      chk("resp_onehot", 32'($countones({a, v})), 32'd1);
      who = -1;
      for (int i = 0; i < N; i++) if (a[i] || v[i]) who = i;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got ack=%b valid=%b, required no response", a, v);
      end else begin
        e = sb.pop_front();
        chk("resp_kind_is_wr", {31'd0, (a != '0)}, {31'd0, e.is_wr});
        chk("resp_client", who, e.client);
        if (!e.is_wr) chk("rd_data", {16'd0, rd_data}, {16'd0, e.data});
      end
      resp_cnt++;
      last_resp_cyc = cyc;
      resp_log.push_back(cyc);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (a[i] && !keep_wr[i]) wr_req[i] = 1'b0;
      if (v[i]) rd_req[i] = 1'b0;
    end
  endtask

  task automatic wait_resp(input int target, input int budget);
    int k = 0;
    while (resp_cnt < target && k < budget) begin
      step();
      k++;
    end
    if (resp_cnt < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d responses, required %0d", resp_cnt, target);
    end
  endtask

  task automatic drive_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[c*AW +: AW] = a;
    wr_data[c*DW +: DW] = d;
    wr_req[c] = 1'b1;
  endtask

  task automatic drive_rd(input int c, input logic [AW-1:0] a);
    rd_addr[c*AW +: AW] = a;
    rd_req[c] = 1'b1;
  endtask

  task automatic push(input bit is_wr, input int c, input logic [DW-1:0] d);
    exp_t e;
    e.is_wr = is_wr; e.client = c; e.data = d;
    sb.push_back(e);
  endtask

  // Single transaction on the MEM_SIZE=6000 instance, client c.
  task automatic op2(input int c, input bit is_wr, input logic [AW-1:0] a,
                     output int lat, output logic [DW-1:0] d, output logic [N-1:0] bits,
                     output logic err_seen, output logic en_seen);
    int t0;
    if (is_wr) begin wr_addr2[c*AW +: AW] = a; wr_data2[c*DW +: DW] = 16'h7777; wr_req2[c] = 1'b1; end
    else       begin rd_addr2[c*AW +: AW] = a; rd_req2[c] = 1'b1; end
    t0 = cyc; lat = -1; d = '0; bits = '0; err_seen = 1'b0; en_seen = 1'b0;
    for (int k = 0; k < 8 && lat < 0; k++) begin
      @(negedge clk);
      if (addr_err2) err_seen = 1'b1;
      if (sram_en2)  en_seen  = 1'b1;
      if ((wr_ack2 | rd_valid2) != '0) begin
        lat = cyc - t0; d = rd_data2; bits = wr_ack2 | rd_valid2;
      end
      @(posedge clk);
      #1;
    end
    wr_req2 = '0;
    rd_req2 = '0;
  endtask

  vec_t vecs[10];

  initial begin
    int t0, base, lat;
    logic [DW-1:0] d;
    logic [N-1:0] bits;
    logic err_seen, en_seen;

    vecs[0] = '{2, 1'b1, 13'h0010, 16'h1234, 16'h0000, 1};
    vecs[1] = '{2, 1'b0, 13'h0010, 16'h0000, 16'h1234, 3};
    vecs[2] = '{0, 1'b1, 13'h1FFF, 16'hBEEF, 16'h0000, 1};
    vecs[3] = '{0, 1'b0, 13'h1FFF, 16'h0000, 16'hBEEF, 3};
    vecs[4] = '{1, 1'b1, 13'h0000, 16'h0001, 16'h0000, 1};
    vecs[5] = '{3, 1'b0, 13'h0010, 16'h0000, 16'h1234, 3};
    vecs[6] = '{1, 1'b0, 13'h0000, 16'h0000, 16'h0001, 3};
    vecs[7] = '{3, 1'b1, 13'h0ABC, 16'h5A5A, 16'h0000, 1};
    vecs[8] = '{3, 1'b0, 13'h0ABC, 16'h0000, 16'h5A5A, 3};
    vecs[9] = '{0, 1'b1, 13'h0123, 16'hCAFE, 16'h0000, 1};

    reset = 1'b1;
    wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    wr_req2 = '0; rd_req2 = '0; wr_addr2 = '0; rd_addr2 = '0; wr_data2 = '0;
    keep_wr = '0;
    step(); step(); step();

    // Reset state.
    chk("reset_wr_ack",   {28'd0, wr_ack},   32'd0);
    chk("reset_rd_valid", {28'd0, rd_valid}, 32'd0);
    chk("reset_rd_data",  {16'd0, rd_data},  32'd0);
    chk("reset_sram_en",  {31'd0, sram_en},  32'd0);
    chk("reset_sram_we",  {31'd0, sram_we},  32'd0);
    chk("reset_sram_addr", {19'd0, sram_addr}, 32'd0);
    chk("reset_sram_wdata", {16'd0, sram_wdata}, 32'd0);
    chk("reset_addr_err", {31'd0, addr_err}, 32'd0);
    reset = 1'b0;

    // Table of single transactions: latency, command and response data.
    for (int i = 0; i < 10; i++) begin
      t0 = cyc;
      if (vecs[i].is_wr) drive_wr(vecs[i].client, vecs[i].addr, vecs[i].wdata);
      else               drive_rd(vecs[i].client, vecs[i].addr);
      push(vecs[i].is_wr, vecs[i].client, vecs[i].exp_rdata);
      wait_resp(resp_cnt + 1, 10);
      chk("latency", last_resp_cyc - t0, vecs[i].exp_lat);
      chk("cmd_cycle", cmd_cyc, t0 + 1);
      chk("cmd_addr", {19'd0, cmd_addr}, {19'd0, vecs[i].addr});
      chk("cmd_we", {31'd0, cmd_we}, {31'd0, vecs[i].is_wr});
      if (vecs[i].is_wr) chk("cmd_wdata", {16'd0, cmd_wdata}, {16'd0, vecs[i].wdata});
    end
    chk("rd_data_hold", {16'd0, rd_data}, 32'h5A5A);

    // rr_ptr is 1 here. Client 2 moves it to 3; then 3 wins, wrap, 0, 1.
    drive_wr(2, 13'h0020, 16'h2222);
    push(1'b1, 2, 16'h0000);
    wait_resp(resp_cnt + 1, 10);
    drive_wr(0, 13'h0021, 16'h2000);
    drive_wr(1, 13'h0022, 16'h2001);
    drive_wr(3, 13'h0023, 16'h2003);
    push(1'b1, 3, 16'h0000);
    push(1'b1, 0, 16'h0000);
    push(1'b1, 1, 16'h0000);
    wait_resp(resp_cnt + 3, 20);

    // rr_ptr is 2. Client 1 raises write and read together: write first,
    // then the reads of 2, 3, 0 come before client 1's own read.
    drive_wr(1, 13'h0030, 16'h3333);
    drive_rd(1, 13'h0ABC);
    push(1'b1, 1, 16'h0000);
    wait_resp(resp_cnt + 1, 10);
    drive_rd(0, 13'h1FFF);
    drive_rd(2, 13'h0010);
    drive_rd(3, 13'h0030);
    push(1'b0, 2, 16'h1234);
    push(1'b0, 3, 16'h3333);
    push(1'b0, 0, 16'hBEEF);
    push(1'b0, 1, 16'h5A5A);
    wait_resp(resp_cnt + 4, 40);

    // All four writers held from reset release: 0,1,2,3,0 every 2 cycles.
    reset = 1'b1;
    step(); step();
    for (int i = 0; i < N; i++) drive_wr(i, 13'(13'h0100 + i), 16'(16'h1000 + i));
    keep_wr = '1;
    reset = 1'b0;
    t0 = cyc;
    resp_log.delete();
    push(1'b1, 0, 16'h0000);
    push(1'b1, 1, 16'h0000);
    push(1'b1, 2, 16'h0000);
    push(1'b1, 3, 16'h0000);
    push(1'b1, 0, 16'h0000);
    wait_resp(resp_cnt + 5, 30);
    wr_req = '0;
    keep_wr = '0;
    if (resp_log.size() == 5) begin
      chk("held_first_lat", resp_log[0] - t0, 1);
      for (int i = 0; i < 4; i++) chk("held_spacing", resp_log[i+1] - resp_log[i], 2);
    end else begin
      chk("held_resp_count", resp_log.size(), 5);
    end

    // rr_ptr is 1. Reset during client 2's RD_WAIT aborts the read.
    drive_rd(2, 13'h0010);
    push(1'b0, 2, 16'h1234);
    step();
    step();
    reset = 1'b1;
    drive_wr(0, 13'h0040, 16'h4444);
    drive_wr(3, 13'h0041, 16'h4445);
    step();
    chk("rst_rd_valid", {28'd0, rd_valid}, 32'd0);
    chk("rst_wr_ack",   {28'd0, wr_ack},   32'd0);
    chk("rst_rd_data",  {16'd0, rd_data},  32'd0);
    chk("rst_sram_en",  {31'd0, sram_en},  32'd0);
    chk("rst_sram_we",  {31'd0, sram_we},  32'd0);
    chk("rst_sram_addr", {19'd0, sram_addr}, 32'd0);
    chk("rst_sram_wdata", {16'd0, sram_wdata}, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    sb.delete();
    base = resp_cnt;
    step();
    chk("rst_no_valid", resp_cnt, base);
    reset = 1'b0;
    push(1'b1, 0, 16'h0000);
    push(1'b0, 2, 16'h1234);
    push(1'b1, 3, 16'h0000);
    wait_resp(resp_cnt + 3, 30);

    // MEM_SIZE=6000 instance: last valid word, then out-of-range read/write.
    op2(0, 1'b0, 13'd5999, lat, d, bits, err_seen, en_seen);
    chk("m6k_inrange_lat", lat, 3);
    chk("m6k_inrange_data", {16'd0, d}, {16'd0, {3'b000, 13'd5999} ^ 16'h5A5A});
    chk("m6k_inrange_err", {31'd0, err_seen}, 32'd0);
    chk("m6k_inrange_en", {31'd0, en_seen}, 32'd1);
    op2(0, 1'b0, 13'd6000, lat, d, bits, err_seen, en_seen);
    chk("m6k_oor_rd_lat", lat, 1);
    chk("m6k_oor_rd_valid", {28'd0, bits}, 32'b0001);
    chk("m6k_oor_rd_data", {16'd0, d}, 32'd0);
    chk("m6k_oor_rd_err", {31'd0, err_seen}, 32'd1);
    chk("m6k_oor_rd_en", {31'd0, en_seen}, 32'd0);
    op2(1, 1'b1, 13'd6001, lat, d, bits, err_seen, en_seen);
    chk("m6k_oor_wr_lat", lat, 1);
    chk("m6k_oor_wr_ack", {28'd0, bits}, 32'b0010);
    chk("m6k_oor_wr_err", {31'd0, err_seen}, 32'd1);
    chk("m6k_oor_wr_en", {31'd0, en_seen}, 32'd0);

    step(); step();
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
